cdb_arbiter: RTL and testbench
==============================

// Module: cdb_arbiter
// PURPOSE
//  Round-robin arbiter sharing the single Common Data Bus among NUM_REQ functional-unit completion ports.
//  Picks at most one completing instruction per cycle and registers it onto the CDB.
//  The CDB feeds the map table (t_plus set on tag match), the RS and the ROB.
//  ROB tag 0 means "no tag" in the map table, so an idle CDB always drives tag 0.
// PARAMETERS
//  NUM_REQ  4   number of FU completion requesters (>=2)
//  TAG_W    5   ROB tag width
//  DATA_W   32  result width
// PORTS
//  clock       in   1                clock
//  reset       in   1                reset, synchronous, active-high
//  squash      in   1                pipeline flush (mispredict); kills in-flight CDB transfer
//  req_valid   in   NUM_REQ          requester i holds a completed result
//  req_tag     in   NUM_REQ*TAG_W    ROB tag of requester i, slice [i*TAG_W +: TAG_W]
//  req_data    in   NUM_REQ*DATA_W   result of requester i, slice [i*DATA_W +: DATA_W]
//  req_ready   out  NUM_REQ          grant; one-hot or zero, combinational
//  cdb_valid   out  1                CDB broadcast valid this cycle
//  cdb_tag     out  TAG_W            broadcast ROB tag; 0 when cdb_valid=0
//  cdb_data    out  DATA_W           broadcast result; 0 when cdb_valid=0
//  cdb_src     out  $clog2(NUM_REQ)  index of granted requester; 0 when idle
//  err_tag0    out  1                sticky: a valid request carried tag 0
// BEHAVIOUR
//  - Reset: rr_ptr=0; cdb_valid=0, cdb_tag=0, cdb_data=0, cdb_src=0, err_tag0=0. req_ready=0 during reset.
//  - Eligible(i) = req_valid[i] && req_tag[i]!=0 && !squash && !reset.
//  - Grant: the first eligible i, scanning rr_ptr, rr_ptr+1, ... mod NUM_REQ.
//    - req_ready[i]=1 for that i only. Purely combinational from inputs and rr_ptr.
//  - Handshake: transfer when req_valid[i] && req_ready[i].
//    - The requester holds valid/tag/data stable until it sees ready.
//    - It may drop valid only on squash.
//  - Latency 1: a transfer in cycle N drives cdb_valid=1 in cycle N+1, with the tag/data/src captured in cycle N.
//  - No transfer in cycle N -> in cycle N+1 cdb_valid=0 and tag/data/src=0.
//  - rr_ptr update:
//    - after a grant to i, rr_ptr <= (i==NUM_REQ-1) ? 0 : i+1;
//    - with no grant, rr_ptr holds.
//    - Wrap: a grant to NUM_REQ-1 sends rr_ptr to 0.
//  - Fairness: a continuously valid requester is granted within NUM_REQ cycles.
//  - Tag 0 with req_valid=1: never granted. err_tag0 <= 1 and stays set until reset.
//  - squash in cycle N:
//    - no grant in N, and cdb_valid=0 in N+1;
//    - rr_ptr holds;
//    - a CDB output already valid in cycle N still completes in N (it was registered in N-1).
//  - reset mid-operation: the pending CDB word is discarded; outputs are 0 from the next edge.
//  - Simultaneous squash and reset: reset dominates.
//  - No backpressure from consumers: the CDB is always accepted.
// TESTING
//  T1 single req: req_valid=0001, tag0=5, data0=0xAB
//     -> ready=0001 in cycle 0; cycle 1: cdb_valid=1, tag=5, data=0xAB, src=0.
//  T2 all four valid, held from ptr=0
//     -> grants 0,1,2,3,0 on consecutive cycles; CDB tags follow one cycle later; no idle gaps.
//  T3 wrap: ptr=3, req_valid=1001
//     -> grant 3, then 0; ptr goes 3 -> 0 -> 1.
//  T4 squash: req_valid=0110, squash=1 for one cycle
//     -> ready=0000, cdb_valid=0 next cycle, ptr unchanged; the following cycle grants 1.
//  T5 tag0: req_valid=0100 with tag2=0
//     -> ready=0000, cdb_valid stays 0, err_tag0=1 and sticky; reset clears it.
//  T6 reset mid-stream: assert reset the cycle after a grant
//     -> cdb_valid=0, tag=0, ptr=0 after the edge; first grant post-reset goes to the lowest valid index.

Source files
------------

// File: rtl/cdb_arbiter.sv
// rtl/cdb_arbiter.sv - round-robin arbiter driving the registered Common Data Bus
module cdb_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int TAG_W   = 5,
  parameter int DATA_W  = 32,
  localparam int SRC_W  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic                      squash,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [NUM_REQ*TAG_W-1:0]  req_tag,
  input  logic [NUM_REQ*DATA_W-1:0] req_data,
  output logic [NUM_REQ-1:0]        req_ready,
  output logic                      cdb_valid,
  output logic [TAG_W-1:0]          cdb_tag,
  output logic [DATA_W-1:0]         cdb_data,
  output logic [SRC_W-1:0]          cdb_src,
  output logic                      err_tag0
);

  logic [SRC_W-1:0]  rr_ptr_q, rr_ptr_d;
  logic              cdb_valid_q;
  logic [TAG_W-1:0]  cdb_tag_q;
  logic [DATA_W-1:0] cdb_data_q;
  logic [SRC_W-1:0]  cdb_src_q;
  logic              err_tag0_q;

  logic [NUM_REQ-1:0] tag_zero;
  logic [NUM_REQ-1:0] elig;
  logic [NUM_REQ-1:0] elig_hi;
  logic               use_hi;
  logic               grant_any;
  logic [SRC_W-1:0]   grant_idx;

  // Qualify requests: tag 0 is the map table's "no tag" and can never be broadcast.
  always_comb begin
    tag_zero = '0;
    elig     = '0;
    elig_hi  = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      tag_zero[i] = req_valid[i] && (req_tag[i*TAG_W +: TAG_W] == '0);
      elig[i]     = req_valid[i] && !tag_zero[i] && !squash && !reset;
      elig_hi[i]  = elig[i] && (i >= int'(rr_ptr_q));
    end
  end

  // Rotating priority: lowest eligible index at or above rr_ptr, else lowest overall.
  always_comb begin
    use_hi    = |elig_hi;
    grant_any = |elig;
    grant_idx = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (use_hi ? elig_hi[i] : elig[i]) begin
        grant_idx = SRC_W'(i);
      end
    end
    req_ready = grant_any ? ({{(NUM_REQ-1){1'b0}}, 1'b1} << grant_idx) : '0;
    if (!grant_any) begin
      rr_ptr_d = rr_ptr_q;
    end else if (grant_idx == SRC_W'(NUM_REQ - 1)) begin
      rr_ptr_d = '0;
    end else begin
      rr_ptr_d = grant_idx + 1'b1;
    end
  end

  // Register the granted word onto the CDB; idle cycles broadcast all zeros.
  always_ff @(posedge clock) begin
    if (reset) begin
      rr_ptr_q    <= '0;
      cdb_valid_q <= 1'b0;
      cdb_tag_q   <= '0;
      cdb_data_q  <= '0;
      cdb_src_q   <= '0;
      err_tag0_q  <= 1'b0;
    end else begin
      rr_ptr_q    <= rr_ptr_d;
      cdb_valid_q <= grant_any;
      cdb_tag_q   <= grant_any ? req_tag[grant_idx*TAG_W +: TAG_W] : '0;
      cdb_data_q  <= grant_any ? req_data[grant_idx*DATA_W +: DATA_W] : '0;
      cdb_src_q   <= grant_any ? grant_idx : '0;
      err_tag0_q  <= err_tag0_q | (|tag_zero);
    end
  end

  assign cdb_valid = cdb_valid_q;
  assign cdb_tag   = cdb_tag_q;
  assign cdb_data  = cdb_data_q;
  assign cdb_src   = cdb_src_q;
  assign err_tag0  = err_tag0_q;

endmodule

// File: tb/tb_cdb_arbiter.sv
// tb/tb_cdb_arbiter.sv - directed and randomized checks of the CDB arbiter
module tb_cdb_arbiter;
  localparam int N  = 4;
  localparam int TW = 5;
  localparam int DW = 32;

  logic            clock = 1'b0;
  logic            reset;
  logic            squash;
  logic [N-1:0]    req_valid;
  logic [N*TW-1:0] req_tag;
  logic [N*DW-1:0] req_data;
  logic [N-1:0]    req_ready;
  logic            cdb_valid;
  logic [TW-1:0]   cdb_tag;
  logic [DW-1:0]   cdb_data;
  logic [1:0]      cdb_src;
  logic            err_tag0;

  int n_checks = 0;
  int n_err    = 0;

  // Reference model state
  int            m_ptr  = 0;
  logic          m_v    = 1'b0;
  logic [TW-1:0] m_tag  = '0;
  logic [DW-1:0] m_data = '0;
  int            m_src  = 0;
  logic          m_err  = 1'b0;

  cdb_arbiter #(.NUM_REQ(N), .TAG_W(TW), .DATA_W(DW)) dut (
    .clock(clock), .reset(reset), .squash(squash),
    .req_valid(req_valid), .req_tag(req_tag), .req_data(req_data),
    .req_ready(req_ready), .cdb_valid(cdb_valid), .cdb_tag(cdb_tag),
    .cdb_data(cdb_data), .cdb_src(cdb_src), .err_tag0(err_tag0)
  );

  always #5 clock = ~clock;

  // Scan rr_ptr, rr_ptr+1, ... mod N for the first eligible requester; -1 if none.
  function automatic int model_pick();
    for (int k = 0; k < N; k++) begin
      int idx;
      idx = (m_ptr + k) % N;
      if (req_valid[idx] && req_tag[idx*TW +: TW] != 0 && !squash && !reset) return idx;
    end
    return -1;
  endfunction

  task automatic model_advance();
    int g;
    g = model_pick();
    if (reset) begin
      m_ptr = 0; m_v = 0; m_tag = 0; m_data = 0; m_src = 0; m_err = 0;
    end else begin
      if (g >= 0) begin
        m_v = 1; m_tag = req_tag[g*TW +: TW]; m_data = req_data[g*DW +: DW]; m_src = g;
        m_ptr = (g + 1) % N;
      end else begin
        m_v = 0; m_tag = 0; m_data = 0; m_src = 0;
      end
      for (int i = 0; i < N; i++)
        if (req_valid[i] && req_tag[i*TW +: TW] == 0) m_err = 1;
    end
  endtask

  task automatic cycle();
    model_advance();
    @(posedge clock);
    @(negedge clock);
  endtask

  task automatic set_req(input int i, input logic v, input logic [TW-1:0] t, input logic [DW-1:0] d);
    req_valid[i] = v;
    req_tag[i*TW +: TW] = t;
    req_data[i*DW +: DW] = d;
  endtask

  task automatic test_reset();
    reset = 1; squash = 0;
    for (int i = 0; i < N; i++) set_req(i, 1, 5'(i + 1), 32'hDEAD_0000 + i);
    #1;
    n_checks++; if (req_ready !== 4'b0000) begin n_err++; $display("FAIL reset_ready: got %b want 0000", req_ready); end
    cycle();
    #1;
    n_checks++; if ({cdb_valid, cdb_tag, cdb_data, cdb_src, err_tag0} !== '0) begin
      n_err++; $display("FAIL reset_outputs: got v=%b tag=%0d data=%h src=%0d err=%b want all 0", cdb_valid, cdb_tag, cdb_data, cdb_src, err_tag0); end
    reset = 0; req_valid = '0;
    cycle();
  endtask

  task automatic test_single();
    set_req(0, 1, 5, 32'hAB);
    #1;
    n_checks++; if (req_ready !== 4'b0001) begin n_err++; $display("FAIL t1_ready: got %b want 0001", req_ready); end
    cycle();
    set_req(0, 0, 0, 0);
    #1;
    n_checks++; if (cdb_valid !== 1 || cdb_tag !== 5 || cdb_data !== 32'hAB || cdb_src !== 0) begin
      n_err++; $display("FAIL t1_cdb: got v=%b tag=%0d data=%h src=%0d want 1/5/ab/0", cdb_valid, cdb_tag, cdb_data, cdb_src); end
    cycle();
    #1;
    n_checks++; if (cdb_valid !== 0 || cdb_tag !== 0 || cdb_data !== 0) begin
      n_err++; $display("FAIL t1_idle: got v=%b tag=%0d data=%h want zeros", cdb_valid, cdb_tag, cdb_data); end
  endtask

  task automatic test_round_robin();
    logic [TW-1:0] prev_tag;
    // pointer starts at 0 after a fresh reset
    reset = 1; cycle(); reset = 0;
    prev_tag = 0;
    for (int i = 0; i < N; i++) set_req(i, 1, 5'(i + 1), 32'h100 + i);
    for (int k = 0; k < 5; k++) begin
      int g;
      g = k % N;
      #1;
      n_checks++; if (req_ready !== 4'(1 << g)) begin n_err++; $display("FAIL t2_grant%0d: got %b want %b", k, req_ready, 4'(1 << g)); end
      if (k > 0) begin
        n_checks++; if (cdb_valid !== 1 || cdb_tag !== prev_tag) begin
          n_err++; $display("FAIL t2_cdb%0d: got v=%b tag=%0d want 1/%0d", k, cdb_valid, cdb_tag, prev_tag); end
      end
      prev_tag = req_tag[g*TW +: TW];
      cycle();
      set_req(g, 1, 5'(prev_tag + 4), 32'h200 + g);
    end
    #1;
    n_checks++; if (cdb_valid !== 1 || cdb_tag !== 5'd5 || cdb_src !== 0) begin
      n_err++; $display("FAIL t2_last: got v=%b tag=%0d src=%0d want 1/5/0", cdb_valid, cdb_tag, cdb_src); end
    req_valid = '0;
    cycle();
  endtask

  task automatic test_wrap();
    // pointer is 1 here; a grant to 2 moves it to 3
    set_req(2, 1, 7, 32'h77);
    #1;
    n_checks++; if (req_ready !== 4'b0100) begin n_err++; $display("FAIL t3_pre: got %b want 0100", req_ready); end
    cycle();
    set_req(2, 0, 0, 0); set_req(3, 1, 9, 32'h99); set_req(0, 1, 10, 32'hA0);
    #1;
    n_checks++; if (req_ready !== 4'b1000) begin n_err++; $display("FAIL t3_grant3: got %b want 1000", req_ready); end
    cycle();
    set_req(3, 0, 0, 0);
    #1;
    n_checks++; if (req_ready !== 4'b0001 || cdb_src !== 3 || cdb_tag !== 9) begin
      n_err++; $display("FAIL t3_grant0: got ready=%b src=%0d tag=%0d want 0001/3/9", req_ready, cdb_src, cdb_tag); end
    cycle();
    set_req(0, 1, 12, 32'hC0); set_req(1, 1, 11, 32'hB0);
    #1;
    n_checks++; if (req_ready !== 4'b0010 || cdb_src !== 0 || cdb_tag !== 10) begin
      n_err++; $display("FAIL t3_ptr1: got ready=%b src=%0d tag=%0d want 0010/0/10", req_ready, cdb_src, cdb_tag); end
    cycle();
    req_valid = '0;
    #1;
    n_checks++; if (cdb_src !== 1 || cdb_tag !== 11) begin n_err++; $display("FAIL t3_cdb1: got src=%0d tag=%0d want 1/11", cdb_src, cdb_tag); end
    cycle();
  endtask

  task automatic test_squash();
    // pointer is 2; requester 0 wins and moves it to 1
    set_req(0, 1, 3, 32'h33);
    #1;
    n_checks++; if (req_ready !== 4'b0001) begin n_err++; $display("FAIL t4_pre: got %b want 0001", req_ready); end
    cycle();
    set_req(0, 0, 0, 0); set_req(1, 1, 13, 32'hD1); set_req(2, 1, 14, 32'hE2); squash = 1;
    #1;
    n_checks++; if (req_ready !== 4'b0000 || cdb_valid !== 1 || cdb_tag !== 3) begin
      n_err++; $display("FAIL t4_squash: got ready=%b v=%b tag=%0d want 0000/1/3", req_ready, cdb_valid, cdb_tag); end
    cycle();
    squash = 0;
    #1;
    n_checks++; if (cdb_valid !== 0 || req_ready !== 4'b0010) begin
      n_err++; $display("FAIL t4_after: got v=%b ready=%b want 0/0010", cdb_valid, req_ready); end
    cycle();
    set_req(1, 0, 0, 0);
    #1;
    n_checks++; if (req_ready !== 4'b0100 || cdb_src !== 1 || cdb_tag !== 13) begin
      n_err++; $display("FAIL t4_next: got ready=%b src=%0d tag=%0d want 0100/1/13", req_ready, cdb_src, cdb_tag); end
    cycle();
    set_req(2, 0, 0, 0);
    cycle();
  endtask

  task automatic test_tag0();
    set_req(2, 1, 0, 32'h5555);
    #1;
    n_checks++; if (req_ready !== 4'b0000 || err_tag0 !== 0) begin
      n_err++; $display("FAIL t5_pre: got ready=%b err=%b want 0000/0", req_ready, err_tag0); end
    cycle();
    #1;
    n_checks++; if (req_ready !== 4'b0000 || cdb_valid !== 0 || err_tag0 !== 1) begin
      n_err++; $display("FAIL t5_err: got ready=%b v=%b err=%b want 0000/0/1", req_ready, cdb_valid, err_tag0); end
    squash = 1; set_req(2, 0, 0, 0);
    cycle();
    squash = 0;
    cycle();
    #1;
    n_checks++; if (err_tag0 !== 1) begin n_err++; $display("FAIL t5_sticky: got %b want 1", err_tag0); end
    reset = 1;
    cycle();
    reset = 0;
    #1;
    n_checks++; if (err_tag0 !== 0) begin n_err++; $display("FAIL t5_clear: got %b want 0", err_tag0); end
  endtask

  task automatic test_reset_mid();
    set_req(1, 1, 17, 32'h17); set_req(2, 1, 18, 32'h18);
    #1;
    n_checks++; if (req_ready !== 4'b0010) begin n_err++; $display("FAIL t6_grant: got %b want 0010", req_ready); end
    cycle();
    set_req(1, 0, 0, 0); reset = 1; squash = 1;
    #1;
    n_checks++; if (req_ready !== 4'b0000 || cdb_valid !== 1 || cdb_tag !== 17) begin
      n_err++; $display("FAIL t6_inreset: got ready=%b v=%b tag=%0d want 0000/1/17", req_ready, cdb_valid, cdb_tag); end
    cycle();
    reset = 0; squash = 0; set_req(1, 1, 19, 32'h19);
    #1;
    n_checks++; if (cdb_valid !== 0 || cdb_tag !== 0 || cdb_data !== 0 || req_ready !== 4'b0010) begin
      n_err++; $display("FAIL t6_post: got v=%b tag=%0d data=%h ready=%b want 0/0/0/0010", cdb_valid, cdb_tag, cdb_data, req_ready); end
    cycle();
    set_req(1, 0, 0, 0);
    #1;
    n_checks++; if (cdb_tag !== 19 || req_ready !== 4'b0100) begin
      n_err++; $display("FAIL t6_next: got tag=%0d ready=%b want 19/0100", cdb_tag, req_ready); end
    cycle();
    set_req(2, 0, 0, 0);
    cycle();
  endtask

  task automatic test_random();
    logic [N-1:0] last_grant;
    logic         last_flush;
    last_grant = '0;
    last_flush = 0;
    for (int c = 0; c < 400; c++) begin
      int g;
      logic [N-1:0] exp_ready;
      // requesters hold until granted; they may change freely after a squash or reset
      for (int i = 0; i < N; i++) begin
        if (!req_valid[i] || last_grant[i] || last_flush) begin
          logic [TW-1:0] t;
          t = ($urandom_range(0, 99) < 4) ? 5'd0 : 5'($urandom_range(1, 31));
          set_req(i, ($urandom_range(0, 99) < 60), t, $urandom);
        end
      end
      squash = ($urandom_range(0, 99) < 8);
      reset  = ($urandom_range(0, 99) < 2);
      #1;
      g = model_pick();
      exp_ready = (g >= 0) ? 4'(1 << g) : 4'b0000;
      n_checks++; if (req_ready !== exp_ready) begin n_err++; $display("FAIL rnd_ready c=%0d: got %b want %b", c, req_ready, exp_ready); end
      n_checks++; if (cdb_valid !== m_v) begin n_err++; $display("FAIL rnd_valid c=%0d: got %b want %b", c, cdb_valid, m_v); end
      n_checks++; if (cdb_tag !== m_tag) begin n_err++; $display("FAIL rnd_tag c=%0d: got %0d want %0d", c, cdb_tag, m_tag); end
      n_checks++; if (cdb_data !== m_data) begin n_err++; $display("FAIL rnd_data c=%0d: got %h want %h", c, cdb_data, m_data); end
      n_checks++; if (cdb_src !== 2'(m_src)) begin n_err++; $display("FAIL rnd_src c=%0d: got %0d want %0d", c, cdb_src, m_src); end
      n_checks++; if (err_tag0 !== m_err) begin n_err++; $display("FAIL rnd_err c=%0d: got %b want %b", c, err_tag0, m_err); end
      last_grant = exp_ready;
      last_flush = squash | reset;
      cycle();
    end
    reset = 0; squash = 0; req_valid = '0;
    cycle();
  endtask

  initial begin
    reset = 1; squash = 0; req_valid = '0; req_tag = '0; req_data = '0;
    @(negedge clock);
    test_reset();
    test_single();
    test_round_robin();
    test_wrap();
    test_squash();
    test_tag0();
    test_reset_mid();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
